// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared types and helpers for the MEM-stage access unit.
//   mem_state_t  - control FSM states
//   mem_size_t   - access size encoding (MEM_B/H/W/D)
//   mem_op_t     - instruction fields captured when an access is accepted
//   size_mask()  - base byte-enable mask for a size, before lane shift
//   is_misaligned() - natural-alignment check for a size and low address bits
package mem_pkg;

  localparam int MEM_DW = 64;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} mem_state_t;

  typedef logic [1:0] mem_size_t;
  localparam mem_size_t MEM_B = 2'd0;
  localparam mem_size_t MEM_H = 2'd1;
  localparam mem_size_t MEM_W = 2'd2;
  localparam mem_size_t MEM_D = 2'd3;

  typedef struct packed {
    logic              write;
    logic [MEM_DW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
    mem_size_t         size;
    logic              uns;
  } mem_op_t;

  function automatic logic [7:0] size_mask(mem_size_t size);
    case (size)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_size_t size, logic [2:0] lo);
    case (size)
      MEM_H:   return lo[0] != 1'b0;
      MEM_W:   return lo[1:0] != 2'b00;
      MEM_D:   return lo != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response channel.
//   master: the access unit (drives request fields, sees ready + response)
//   slave : the data memory
//   req_valid/ready handshake; req_write 1=store; req_addr 8-byte aligned;
//   req_wdata lane-shifted; req_wstrb byte enables; resp_valid acks both
//   loads and stores, resp_rdata is the aligned 8-byte read data.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH/8
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_write;
  logic [DATA_WIDTH-1:0] dmem_req_addr;
  logic [DATA_WIDTH-1:0] dmem_req_wdata;
  logic [STRB_WIDTH-1:0] dmem_req_wstrb;
  logic                  dmem_resp_valid;
  logic [DATA_WIDTH-1:0] dmem_resp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_write, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
//   lane      - addr[2:0] of the access
//   size/uns  - access size, zero-extend when uns=1
//   rdata_in  - 8-byte aligned read data -> load_data (shifted + extended)
//   wdata_in  - LSB-justified store data -> wdata_out (shifted to lane)
//   wstrb     - byte enables for the store
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic [2:0]            lane,
  input  mem_size_t             size,
  input  logic                  uns,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] wdata_out,
  output logic [STRB_WIDTH-1:0] wstrb
);
  logic [5:0]            sh;
  logic [DATA_WIDTH-1:0] rsh;

  assign sh  = {lane, 3'b000};
  assign rsh = rdata_in >> sh;

  // Extension bit is the top bit of the selected field, forced to 0 for
  // unsigned loads.
  always_comb begin
    load_data = rsh;
    case (size)
      MEM_B: load_data = {{(DATA_WIDTH-8){~uns & rsh[7]}},   rsh[7:0]};
      MEM_H: load_data = {{(DATA_WIDTH-16){~uns & rsh[15]}}, rsh[15:0]};
      MEM_W: load_data = {{(DATA_WIDTH-32){~uns & rsh[31]}}, rsh[31:0]};
      default: load_data = rsh;
    endcase
  end

  assign wdata_out = wdata_in << sh;
  assign wstrb     = size_mask(size) << lane;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer.
//   clk, reset (async, active low), flush (kill current instruction)
//   mem_read_in/mem_write_in/addr_in/write_data_in/size_in/unsigned_in
//     - EX/MEM register outputs describing the current instruction
//   dmem          - request/response channel to data memory (master side)
//   stall_out     - hold upstream stages while an access is in flight
//   load_data_out - aligned/extended load result, held until next capture
//   done_out      - one-cycle completion pulse
//   misaligned_out- with done_out: access faulted, nothing sent to memory
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [DATA_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  mem_size_t             size_in,
  input  logic                  unsigned_in,
  mem_access_unit_if.master     dmem,
  output logic                  stall_out,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  done_out,
  output logic                  misaligned_out
);

  mem_state_t            state, state_nxt;
  mem_op_t               op_q;
  logic                  fault_q, kill_q;
  logic [DATA_WIDTH-1:0] load_q;

  logic                  op_req, take, mis;
  logic [DATA_WIDTH-1:0] ld_aligned, st_wdata;
  logic [STRB_WIDTH-1:0] st_wstrb;

  assign op_req = mem_read_in | mem_write_in;
  assign take   = (state == IDLE) & op_req & ~flush;
  assign mis    = is_misaligned(size_in, addr_in[2:0]);

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH), .STRB_WIDTH(STRB_WIDTH)) u_align (
    .lane      (op_q.addr[2:0]),
    .size      (op_q.size),
    .uns       (op_q.uns),
    .rdata_in  (dmem.dmem_resp_rdata),
    .wdata_in  (op_q.wdata),
    .load_data (ld_aligned),
    .wdata_out (st_wdata),
    .wstrb     (st_wstrb)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (take) state_nxt = mis ? DONE : REQ;
      // A kill raised while waiting for ready (or on the accepting cycle)
      // still lets the request go out; its response must be swallowed.
      REQ:   if (dmem.dmem_req_ready) state_nxt = (kill_q | flush) ? DRAIN : WAIT;
      WAIT: begin
        if (dmem.dmem_resp_valid) state_nxt = flush ? IDLE : DONE;
        else if (flush)           state_nxt = DRAIN;
      end
      DRAIN: if (dmem.dmem_resp_valid) state_nxt = IDLE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured instruction, fault/kill flags and load result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      fault_q <= 1'b0;
      kill_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      if (take) begin
        op_q.write <= mem_write_in;  // store wins when both are set
        op_q.addr  <= addr_in;
        op_q.wdata <= write_data_in;
        op_q.size  <= size_in;
        op_q.uns   <= unsigned_in;
        fault_q    <= mis;
        kill_q     <= 1'b0;
        load_q     <= '0;
      end
      if (state == REQ && flush) kill_q <= 1'b1;
      if (state == WAIT && dmem.dmem_resp_valid && !flush && !op_q.write)
        load_q <= ld_aligned;
    end
  end

  // Outputs
  always_comb begin
    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_req_write = 1'b0;
    dmem.dmem_req_addr  = '0;
    dmem.dmem_req_wdata = '0;
    dmem.dmem_req_wstrb = '0;
    stall_out           = 1'b0;
    done_out            = 1'b0;
    misaligned_out      = 1'b0;
    case (state)
      // reset gates the input-driven term so every output is 0 in reset
      IDLE: stall_out = reset & op_req & ~flush;
      REQ: begin
        stall_out           = 1'b1;
        dmem.dmem_req_valid = 1'b1;
        dmem.dmem_req_write = op_q.write;
        dmem.dmem_req_addr  = {op_q.addr[DATA_WIDTH-1:3], 3'b000};
        dmem.dmem_req_wdata = op_q.write ? st_wdata : '0;
        dmem.dmem_req_wstrb = op_q.write ? st_wstrb : '0;
      end
      WAIT, DRAIN: stall_out = 1'b1;
      DONE: begin
        done_out       = 1'b1;
        misaligned_out = fault_q;
      end
      default: ;
    endcase
  end

  assign load_data_out = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, mem_read_in, mem_write_in, unsigned_in;
  logic [63:0] addr_in, write_data_in;
  logic [1:0]  size_in;
  logic        stall_out, done_out, misaligned_out;
  logic [63:0] load_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_WIDTH(64)) dmem();

  mem_access_unit #(.DATA_WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .write_data_in  (write_data_in),
    .size_in        (size_in),
    .unsigned_in    (unsigned_in),
    .dmem           (dmem),
    .stall_out      (stall_out),
    .load_data_out  (load_data_out),
    .done_out       (done_out),
    .misaligned_out (misaligned_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic from the access rules
  function automatic bit exp_mis(input logic [63:0] a, input int sz);
    return (int'(a[2:0]) % (1 << sz)) != 0;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] a,
                                           input int sz, input bit uns);
    logic [63:0] s, m, v;
    int nb;
    s  = rdata >> (8 * int'(a[2:0]));
    nb = 8 << sz;
    if (nb == 64) return s;
    m = (64'd1 << nb) - 64'd1;
    v = s & m;
    if (!uns && s[nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] exp_wstrb(input logic [63:0] a, input int sz);
    int m;
    m = ((1 << (1 << sz)) - 1) << int'(a[2:0]);
    return m[7:0];
  endfunction

  // One instruction, cycle by cycle. Cycle 0 = op first seen in IDLE.
  // rdly: cycles of req_ready low; pdly: extra cycles before the response;
  // fcyc: cycle carrying a one-cycle flush (-1 = none).
  task automatic run_op(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                        input int sz, input bit uns, input logic [63:0] rdata,
                        input int rdly, input int pdly, input int fcyc);
    bit mis, active, killed, inreq, ld_ok;
    int acc, rsp, done_c, exp_done, stall_end, hold_end, last;
    mis      = exp_mis(a, sz);
    acc      = 1 + rdly;
    rsp      = acc + 1 + pdly;
    done_c   = mis ? 1 : rsp + 1;
    active   = !mis && fcyc != 0;
    killed   = fcyc >= 0 && fcyc < done_c;
    exp_done = killed ? -1 : done_c;
    stall_end = (fcyc == 0) ? -1 : (mis ? 0 : rsp);
    hold_end = (fcyc >= 0) ? fcyc : done_c;
    ld_ok    = rd && !wr && !mis && !killed;
    last     = done_c + 2;
    for (int c = 0; c <= last; c++) begin
      flush         = (c == fcyc);
      mem_read_in   = (c <= hold_end) && rd;
      mem_write_in  = (c <= hold_end) && wr;
      addr_in       = a;
      write_data_in = wd;
      size_in       = 2'(sz);
      unsigned_in   = uns;
      if (active && c >= 1 && c <= acc) dmem.dmem_req_ready = (c == acc);
      else                              dmem.dmem_req_ready = 1'($urandom_range(0, 1));
      dmem.dmem_resp_valid = active && c == rsp;
      dmem.dmem_resp_rdata = (active && c == rsp) ? rdata : {$urandom, $urandom};
      @(negedge clk);
      inreq = active && c >= 1 && c <= acc;
      chk($sformatf("stall c%0d", c), 64'(stall_out), 64'(c <= stall_end));
      chk($sformatf("req_valid c%0d", c), 64'(dmem.dmem_req_valid), 64'(inreq));
      chk($sformatf("done c%0d", c), 64'(done_out), 64'(c == exp_done));
      chk($sformatf("misaligned c%0d", c), 64'(misaligned_out), 64'(c == exp_done && mis));
      if (inreq) begin
        chk("req_addr", dmem.dmem_req_addr, {a[63:3], 3'b000});
        chk("req_write", 64'(dmem.dmem_req_write), 64'(wr));
        chk("req_wstrb", 64'(dmem.dmem_req_wstrb), wr ? 64'(exp_wstrb(a, sz)) : 64'd0);
        if (wr) chk("req_wdata", dmem.dmem_req_wdata, wd << (8 * int'(a[2:0])));
      end
      if (ld_ok && c >= done_c)
        chk($sformatf("load_data c%0d", c), load_data_out, exp_load(rdata, a, sz, uns));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    flush = 0; mem_read_in = 0; mem_write_in = 0; unsigned_in = 0;
    addr_in = '0; write_data_in = '0; size_in = '0;
    dmem.dmem_req_ready = 0; dmem.dmem_resp_valid = 0; dmem.dmem_resp_rdata = '0;
    #1;
    chk("rst stall", 64'(stall_out), 0);
    chk("rst req_valid", 64'(dmem.dmem_req_valid), 0);
    chk("rst done", 64'(done_out), 0);
    chk("rst misaligned", 64'(misaligned_out), 0);
    chk("rst load_data", load_data_out, 0);
    chk("rst wstrb", 64'(dmem.dmem_req_wstrb), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(1, 0, 64'h1003, 64'h0, 0, 0, 64'h0000_0000_80FF_0000, 0, 0, -1);
    chk("tp_load_byte", load_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(0, 1, 64'h2006, 64'hBEEF, 1, 0, 64'h0, 0, 0, -1);
    run_op(1, 0, 64'h10, 64'h0, 2, 1, 64'hFFFF_FFFF_8000_0001, 0, 0, -1);
    chk("tp_load_word_u", load_data_out, 64'h0000_0000_8000_0001);
    run_op(1, 0, 64'h3004, 64'h0, 3, 0, 64'h0, 0, 0, -1);
    run_op(1, 0, 64'h4008, 64'h0, 3, 0, 64'h1234_5678_9ABC_DEF0, 4, 1, 2);
    run_op(1, 0, 64'h5000, 64'h0, 3, 0, 64'h1, 0, 0, 0);      // flush in IDLE
    run_op(1, 0, 64'h6002, 64'h0, 1, 0, 64'h8001_0000, 0, 0, 3); // flush in DONE
    run_op(1, 1, 64'h7005, 64'hA5, 0, 0, 64'h0, 1, 2, -1);     // store wins

    // Reset while waiting for a response
    mem_read_in = 1; addr_in = 64'h8010; size_in = 2'd3; unsigned_in = 0;
    dmem.dmem_req_ready = 0; dmem.dmem_resp_valid = 0;
    @(posedge clk); #1; dmem.dmem_req_ready = 1;
    @(posedge clk); #1; dmem.dmem_req_ready = 0;
    chk("pre-rst stall", 64'(stall_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst stall", 64'(stall_out), 0);
    chk("midrst req_valid", 64'(dmem.dmem_req_valid), 0);
    chk("midrst done", 64'(done_out), 0);
    chk("midrst misaligned", 64'(misaligned_out), 0);
    chk("midrst load_data", load_data_out, 0);
    chk("midrst req_addr", dmem.dmem_req_addr, 0);
    @(posedge clk); #1;
    mem_read_in = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_op(1, 0, 64'h9004, 64'h0, 2, 0, 64'hF000_0000_0000_0000, 0, 1, -1);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      bit rd, wr, uns;
      int k, sz, rdly, pdly, fcyc;
      logic [63:0] a, wd, rdata;
      k     = $urandom_range(0, 2);
      rd    = (k != 1);
      wr    = (k != 0);
      sz    = $urandom_range(0, 3);
      a     = {$urandom, $urandom};
      wd    = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      uns   = 1'($urandom_range(0, 1));
      rdly  = $urandom_range(0, 3);
      pdly  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0)   fcyc = -1;
      else if (exp_mis(a, sz))         fcyc = $urandom_range(0, 1);
      else                             fcyc = $urandom_range(0, rdly + pdly + 3);
      run_op(rd, wr, a, wd, sz, uns, rdata, rdly, pdly, fcyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: mem read/write controls, ALU result as address, store data.
- Issues one request per memory instruction to the data memory over a valid/ready request channel plus a response channel.
- Aligns and sign-extends load data and generates byte strobes for stores.
- Stalls the pipeline while an access is outstanding.

Parameters:
- DATA_WIDTH, 64, data/address width (fixed at 64; lane logic assumes 8 byte lanes)
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill current instruction (branch redirect)
- mem_read_in  in  1  load request, from EX/MEM mem_control[1]
- mem_write_in  in  1  store request, from EX/MEM mem_control[0]
- addr_in  in  DATA_WIDTH  byte address (ALU result)
- write_data_in  in  DATA_WIDTH  store data, LSB-justified
- size_in  in  2  0=byte, 1=half, 2=word, 3=double
- unsigned_in  in  1  zero-extend load when 1
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_write  out  1  1=store, 0=load
- dmem_req_addr  out  DATA_WIDTH  8-byte-aligned address, {addr[63:3],3'b0}
- dmem_req_wdata  out  DATA_WIDTH  lane-shifted store data
- dmem_req_wstrb  out  STRB_WIDTH  byte enables (0 for loads)
- dmem_resp_valid  in  1  response/ack (loads and stores)
- dmem_resp_rdata  in  DATA_WIDTH  8-byte-aligned read data
- stall_out  out  1  hold IF/ID/EX and the EX/MEM register
- load_data_out  out  DATA_WIDTH  aligned and extended load result
- done_out  out  1  one-cycle pulse: access complete, results valid
- misaligned_out  out  1  with done_out: access faulted, no memory request issued

Behaviour:
- Reset (async, reset=0): state IDLE; every output 0; internal captured op cleared.
- op = mem_read_in | mem_write_in. If both are asserted, the store wins.
- Misalignment rules:
  - half: addr[0] != 0
  - word: addr[1:0] != 0
  - double: addr[2:0] != 0
  - byte: never misaligned
- States:
  - IDLE, with op and no flush:
    - capture address, data, size, unsigned and write bit
    - if misaligned, go to DONE with the fault flag set
    - otherwise go to REQ
  - IDLE, with flush: ignore the op and stay in IDLE.
  - REQ:
    - dmem_req_valid=1; request fields held stable until accepted
    - on valid&ready, go to WAIT (or DRAIN if killed)
    - the request is never withdrawn before acceptance
  - WAIT: on dmem_resp_valid, register the aligned load data and go to DONE.
  - DONE: done_out=1 and misaligned_out=fault flag; load_data_out holds its value until the next capture; next state IDLE.
  - DRAIN: on dmem_resp_valid, discard the data and go to IDLE; no done_out.
- Latency: op seen in IDLE at cycle 0, req_valid at cycle 1. With zero-wait ready and the response in the cycle after acceptance, done_out is at cycle 3. The minimum for a misaligned access is done_out at cycle 1.
- stall_out (combinational) = (IDLE & op & !flush) | REQ | WAIT | DRAIN. It is low in DONE so EX/MEM advances and MEM/WB captures the result.
- Flush handling:
  - flush in REQ: set kill; stay in REQ until accepted, then DRAIN.
  - flush in WAIT: go to DRAIN, unless resp_valid is high in the same cycle, in which case go to IDLE.
  - flush in DONE: done_out still pulses; downstream discards it.
- Load alignment: lane = addr[2:0]; shift rdata right by lane×8; then
  - byte: sign/zero-extend bits [7:0]
  - half: sign/zero-extend bits [15:0]
  - word: sign/zero-extend bits [31:0]
  - double: pass through
- Store alignment:
  - wdata = write_data_in << (lane×8), truncated to 64 bits
  - wstrb = {1, 3, 15, 255}[size] << lane
- Reset mid-operation: return immediately to IDLE with all outputs 0. Any outstanding response afterwards is memory-side responsibility.

Decomposition:
- Package mem_pkg holds:
  - enum mem_state_t {IDLE, REQ, WAIT, DRAIN, DONE}
  - size encodings MEM_B/MEM_H/MEM_W/MEM_D
  - function size_mask(size) returning the base byte mask
- One combinational sub-module, mem_lane_align: load extract/extend plus store shift/strobe generation, instantiated once.

Test Plan:
- Load byte, addr=0x1003, signed, rdata=0x0000_0000_80FF_0000, ready=1, resp one cycle later -> req_addr 0x1000, wstrb 0, load_data_out 0xFFFF_FFFF_FFFF_FF80? No: lane 3 byte = 0x80 -> 0xFFFF_FFFF_FFFF_FF80, done_out at cycle 3, stall_out high cycles 0-2.
- Store half, addr=0x2006, data=0xBEEF -> wstrb 0xC0, wdata 0xBEEF_0000_0000_0000, req_write 1; done_out after ack.
- Load word unsigned, addr=0x10, rdata=0xFFFF_FFFF_8000_0001 -> 0x0000_0000_8000_0001.
- Misaligned double, addr=0x3004 -> no req_valid ever, done_out=1 and misaligned_out=1 at cycle 1, stall_out high cycle 0 only.
- req_ready held low for 4 cycles, flush asserted in cycle 2 -> valid/addr stable until accepted, DRAIN swallows the response, no done_out, stall_out high throughout.
- reset asserted in WAIT -> outputs 0 asynchronously; after release, a new load completes normally.
